// File: rtl/mult_issue_ctrl_if.sv
// rtl/mult_issue_ctrl_if.sv - operand input and product output streams of mult_issue_ctrl
interface mult_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - issue/capture controller for the 9-cycle iterative multiplier (MULT_ISSUE_ACC_EN adds a product accumulator)
module mult_issue_ctrl #(
    parameter int MULT_PERIOD = 9,
    parameter int PH_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    mult_issue_ctrl_if.slave s,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_prod,
`ifdef MULT_ISSUE_ACC_EN
    input  logic        acc_clear,
    output logic [23:0] out_acc,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(MULT_PERIOD - 1);

    state_t           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic [15:0]      out_prod_q, out_prod_d;
    logic             out_valid_q, out_valid_d;
    logic             load_edge;
    logic             capture;
`ifdef MULT_ISSUE_ACC_EN
    logic [23:0]      acc_q, acc_d;
`endif

    // the multiplier loads its operands whenever this edge samples phase 0
    assign load_edge = (ph_q == '0);

    // mirror of the multiplier's internal load counter
    always_comb begin
        ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end

    // issue FSM, operand hold registers and product capture
    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_prod_d  = out_prod_q;
        out_valid_d = out_valid_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (s.in_valid) begin
                    mul_a_d = s.in_a;
                    mul_b_d = s.in_b;
                    state_d = ARMED;
                end
            end
            // entered after the accept edge, so the next load edge always sees the new operands
            ARMED: begin
                if (load_edge) state_d = COMPUTE;
            end
            // a blocked capture lets the multiplier rerun the same operands
            COMPUTE: begin
                if (load_edge && (!out_valid_q || s.out_ready)) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (out_valid_q && s.out_ready) out_valid_d = 1'b0;
        if (capture) begin
            out_valid_d = 1'b1;
            out_prod_d  = mul_prod;
        end
    end

`ifdef MULT_ISSUE_ACC_EN
    // running sum of captured products, wrapping at 24 bits
    always_comb begin
        acc_d = acc_q;
        if (capture)        acc_d = acc_clear ? 24'(mul_prod) : acc_q + 24'(mul_prod);
        else if (acc_clear) acc_d = '0;
    end

    // accumulator register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign out_acc = acc_q;
`endif

    // state registers, cleared together with the multiplier's own counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_prod_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_prod_q  <= out_prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s.in_ready  = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign s.out_valid = out_valid_q;
    assign s.out_prod  = out_prod_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb/tb_mult_issue_ctrl.sv - directed self-checking bench for mult_issue_ctrl
`timescale 1ns/1ps
module tb_mult_issue_ctrl;
    logic        clk;
    logic        reset;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_prod;
    logic        busy;
`ifdef MULT_ISSUE_ACC_EN
    logic        acc_clear;
    logic [23:0] out_acc;
`endif

    mult_issue_ctrl_if bus ();

    mult_issue_ctrl #(.MULT_PERIOD(9), .PH_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (bus),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_prod (mul_prod),
`ifdef MULT_ISSUE_ACC_EN
        .acc_clear(acc_clear),
        .out_acc  (out_acc),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // iterative multiplier stand-in: loads at count 0, result final after 8 more edges
    logic [3:0]  mcnt;
    logic [7:0]  la, lb;
    logic [15:0] mprod;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt <= '0; la <= '0; lb <= '0; mprod <= '0;
        end else begin
            mcnt <= (mcnt == 4'd8) ? 4'd0 : mcnt + 4'd1;
            if (mcnt == 4'd0) begin la <= mul_a; lb <= mul_b; end
            if (mcnt == 4'd8) mprod <= 16'(la) * 16'(lb);
        end
    end
    assign mul_prod = mprod;

    // record every product handed over, with the edge number it left on
    int cyc = 0;
    logic [15:0] mq_prod[$];
    int          mq_cyc[$];
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            mq_prod.push_back(bus.out_prod);
            mq_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_ph(input logic [3:0] p);
        int n = 0;
        @(negedge clk);
        while (mcnt != p && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("wait_ph_timeout", 0, 1);
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 40);
    endtask

    task automatic wait_mq(input int cnt);
        int n = 0;
        while (mq_prod.size() < cnt && n < 80) begin @(negedge clk); n++; end
        chk("mq_count", mq_prod.size(), cnt);
    endtask

    int lat;

    initial begin
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
`ifdef MULT_ISSUE_ACC_EN
        acc_clear = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        reset = 1'b1;

        // idle after reset
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("idle_in_ready", bus.in_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_out_valid", bus.out_valid, 0);
            chk("idle_out_prod", bus.out_prod, 0);
            chk("idle_mul_ab", {mul_a, mul_b}, 0);
        end

        // latency extremes
        wait_ph(4'd8);
        accept(8'd37, 8'd83); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("lat_ph8", lat, 10);
        chk("prod_37x83", bus.out_prod, 3071);
        wait_ph(4'd0);
        accept(8'd255, 8'd255); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("lat_ph0", lat, 18);
        chk("prod_255x255", bus.out_prod, 65025);

        // back-to-back issue
        repeat (2) @(negedge clk);
        mq_prod.delete(); mq_cyc.delete();
        accept(8'd5, 8'd6);
        accept(8'd7, 8'd8);
        accept(8'd9, 8'd10);
        bus.in_valid = 1'b0;
        wait_mq(3);
        if (mq_prod.size() >= 3) begin
            chk("b2b_p0", mq_prod[0], 30);
            chk("b2b_p1", mq_prod[1], 56);
            chk("b2b_p2", mq_prod[2], 90);
            chk("b2b_gap01", mq_cyc[1] - mq_cyc[0], 18);
            chk("b2b_gap12", mq_cyc[2] - mq_cyc[1], 18);
        end
        repeat (20) @(negedge clk);
        chk("b2b_no_extra", mq_prod.size(), 3);

        // backpressure with a queued operand pair
        @(negedge clk);
        bus.out_ready = 1'b0;
        accept(8'd16, 8'd16); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_valid", bus.out_valid, 1);
        accept(8'd100, 8'd100); bus.in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_prod", bus.out_prod, 256);
        end
        chk("bp_busy", busy, 1);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_mul_a", mul_a, 100);
        chk("bp_mul_b", mul_b, 100);
        mq_prod.delete(); mq_cyc.delete();
        wait_ph(4'd3);
        bus.out_ready = 1'b1;
        wait_mq(2);
        if (mq_prod.size() >= 2) begin
            chk("bp_first", mq_prod[0], 256);
            chk("bp_second", mq_prod[1], 10000);
            chk("bp_gap", mq_cyc[1] - mq_cyc[0], 7);
        end

        // reset in the middle of a computation
        wait_ph(4'd1);
        accept(8'd250, 8'd4); bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_mul_a", mul_a, 250);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mul_a", mul_a, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ph(4'd8);
        accept(8'd2, 8'd2); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("post_rst_lat", lat, 10);
        chk("post_rst_prod", bus.out_prod, 4);

`ifdef MULT_ISSUE_ACC_EN
        // accumulator
        @(negedge clk);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        chk("acc_cleared", out_acc, 0);
        accept(8'd10, 8'd10); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("acc_100", out_acc, 100);
        accept(8'd15, 8'd17); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("acc_355", out_acc, 355);
        accept(8'd255, 8'd255); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("acc_65380", out_acc, 65380);
        @(negedge clk);
        acc_clear = 1'b1;
        accept(8'd7, 8'd13); bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("acc_clear_capture", out_acc, 91);
        acc_clear = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
